spi_slave_core: RTL and testbench

Responder end of the SPI link driven by `spi_clk_gen` on the master side. Oversamples the external SCLK/CS_N/MOSI pins in the system clock domain, shifts a DATA_W-bit word in on MOSI and out on MISO in any of the four CPOL/CPHA modes, and exchanges words with local logic through valid/ready handshakes. It sits between the pad ring and the register/FIFO layer of the slave-side design.

---
 rtl/spi_slave_core_pkg.sv | 17 +
 rtl/spi_slave_sync.sv | 32 +++
 rtl/spi_slave_core.sv | 212 +++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_core_pkg.sv
// Shared types and constants for the SPI slave core: default word width, FSM states
// and the bit positions of the latched mode word.
package spi_slave_core_pkg;

  localparam int unsigned SpiSlvDataW = 8;

  localparam int unsigned ModeCphaBit = 0;
  localparam int unsigned ModeCpolBit = 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StWordDone
  } spi_slv_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for an asynchronous pin, plus rise/fall detect of the
// synchronized level against a third delayed stage.
module spi_slave_sync #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
      s3_q <= ResetVal;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI responder core: oversampled SCLK/CS_N/MOSI, all four CPOL/CPHA modes, valid/ready
// word exchange with local logic. Define SPI_SLV_ERR_FLAGS_EN for sticky error flags.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned DATA_W = SpiSlvDataW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_busy,
  output logic              o_tx_underrun,
  output logic              o_rx_overrun,
  input  logic              i_clr_err
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic cs_lvl, cs_fall, unused_cs_rise;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_slave_sync #(.ResetVal(1'b0)) u_sync_sclk (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .din  (i_sclk),
    .lvl  (unused_sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_slave_sync #(.ResetVal(1'b1)) u_sync_cs (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .din  (i_cs_n),
    .lvl  (cs_lvl),
    .rise (unused_cs_rise),
    .fall (cs_fall)
  );

  spi_slave_sync #(.ResetVal(1'b0)) u_sync_mosi (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .din  (i_mosi),
    .lvl  (mosi_lvl),
    .rise (unused_mosi_rise),
    .fall (unused_mosi_fall)
  );

  spi_slv_state_e    state_q;
  logic [1:0]        mode_q;
  logic              lsb_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] rx_sr_q, tx_sr_q, tx_buf_q, rx_data_q;
  logic              miso_q, tx_ready_q, rx_valid_q;

  logic              sample_edge, shift_edge, word_end, rx_take, load_now, tx_wr;
  logic              underrun_evt, overrun_evt;
  logic [DATA_W-1:0] rx_next, load_word;

  function automatic logic out_bit(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? {1'b1, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b1};
  endfunction

  always_comb begin
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    // Leading edge is rising for CPOL=0; CPHA picks which edge samples.
    if (mode_q[ModeCpolBit] ^ mode_q[ModeCphaBit]) begin
      sample_edge = sclk_fall;
      shift_edge  = sclk_rise;
    end else begin
      sample_edge = sclk_rise;
      shift_edge  = sclk_fall;
    end
    rx_next      = lsb_q ? {mosi_lvl, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], mosi_lvl};
    word_end     = (state_q == StShift) && !cs_lvl && sample_edge && (cnt_q == CntLast);
    rx_take      = word_end && (!rx_valid_q || i_rx_ready);
    overrun_evt  = word_end && !rx_take;
    load_now     = ((state_q == StLoad) || (state_q == StWordDone)) && !cs_lvl;
    load_word    = tx_ready_q ? '1 : tx_buf_q;
    underrun_evt = load_now && tx_ready_q;
    tx_wr        = i_tx_valid && tx_ready_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      lsb_q      <= 1'b0;
      cnt_q      <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      if (rx_valid_q && i_rx_ready) rx_valid_q <= 1'b0;
      if (rx_take) begin
        rx_data_q  <= rx_next;
        rx_valid_q <= 1'b1;
      end

      if ((state_q != StIdle) && cs_lvl) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        rx_sr_q <= '0;
        tx_sr_q <= '0;
        miso_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              mode_q[ModeCpolBit] <= i_cpol;
              mode_q[ModeCphaBit] <= i_cpha;
              lsb_q               <= i_lsb_first;
              cnt_q               <= '0;
              state_q             <= StLoad;
            end
          end
          StLoad, StWordDone: begin
            tx_ready_q <= 1'b1;
            if (mode_q[ModeCphaBit]) begin
              tx_sr_q <= load_word;
            end else begin
              miso_q  <= out_bit(load_word, lsb_q);
              tx_sr_q <= shift_out(load_word, lsb_q);
            end
            state_q <= StShift;
          end
          StShift: begin
            if (sample_edge) begin
              rx_sr_q <= rx_next;
              if (cnt_q == CntLast) begin
                cnt_q   <= '0;
                state_q <= StWordDone;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            // CPHA=0: first bit went out at load, and the trailing edge after the last
            // sample lands in the next word with cnt_q==0, so it must not shift.
            if (shift_edge && (mode_q[ModeCphaBit] || (cnt_q != '0))) begin
              miso_q  <= out_bit(tx_sr_q, lsb_q);
              tx_sr_q <= shift_out(tx_sr_q, lsb_q);
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      // Placed last: a write alongside an empty-buffer load lands for the next word.
      if (tx_wr) begin
        tx_buf_q   <= i_tx_data;
        tx_ready_q <= 1'b0;
      end
    end
  end

  assign o_miso     = miso_q & ~cs_lvl;
  assign o_miso_oe  = ~cs_lvl;
  assign o_busy     = ~cs_lvl;
  assign o_tx_ready = tx_ready_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;

`ifdef SPI_SLV_ERR_FLAGS_EN
  logic tx_underrun_q, rx_overrun_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      if (underrun_evt)   tx_underrun_q <= 1'b1;
      else if (i_clr_err) tx_underrun_q <= 1'b0;
      if (overrun_evt)    rx_overrun_q  <= 1'b1;
      else if (i_clr_err) rx_overrun_q  <= 1'b0;
    end
  end

  assign o_tx_underrun = tx_underrun_q;
  assign o_rx_overrun  = rx_overrun_q;
`else
  logic unused_err;
  assign unused_err    = ^{i_clr_err, underrun_evt, overrun_evt};
  assign o_tx_underrun = 1'b0;
  assign o_rx_overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: the bench plays SPI master, expected words are
// hand-computed constants.
module tb_spi_slave_core;

  localparam int H = 6;

`ifdef SPI_SLV_ERR_FLAGS_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  logic       clk, rst_n, sclk, cs_n, mosi, cpol, cpha, lsb, clr_err;
  logic       tx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, rx_overrun;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_rises = 0;
  logic rv_prev;

  spi_slave_core #(.DATA_W(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sclk       (sclk),
    .i_cs_n       (cs_n),
    .i_mosi       (mosi),
    .o_miso       (miso),
    .o_miso_oe    (miso_oe),
    .i_cpol       (cpol),
    .i_cpha       (cpha),
    .i_lsb_first  (lsb),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .i_rx_ready   (rx_ready),
    .o_busy       (busy),
    .o_tx_underrun(tx_underrun),
    .o_rx_overrun (rx_overrun),
    .i_clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rv_prev <= rx_valid;
    if (rx_valid && !rv_prev) rx_rises <= rx_rises + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
  endtask

  task automatic accept_rx();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  task automatic cs_begin(input logic pol, input logic ph, input logic lb);
    cpol = pol;
    cpha = ph;
    lsb  = lb;
    sclk = pol;
    cyc(4);
    cs_n = 1'b0;
    cyc(8);
  endtask

  task automatic cs_end();
    cyc(6);
    cs_n = 1'b1;
    cyc(6);
  endtask

  task automatic spi_word(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    int idx;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[idx];
        cyc(H);
        sclk    = ~cpol;
        mi[idx] = miso;
        cyc(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[idx];
        cyc(H);
        sclk    = cpol;
        mi[idx] = miso;
        cyc(H);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    n_checks++; if (miso !== 1'b0)     begin n_fail++; $display("FAIL rst_miso got %b exp 0", miso); end
    n_checks++; if (miso_oe !== 1'b0)  begin n_fail++; $display("FAIL rst_oe got %b exp 0", miso_oe); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_txrdy got %b exp 1", tx_ready); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rxdata got %h exp 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rxvalid got %b exp 0", rx_valid); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_checks++; if ({tx_underrun, rx_overrun} !== 2'b00)
      begin n_fail++; $display("FAIL rst_flags got %b exp 00", {tx_underrun, rx_overrun}); end
    rst_n = 1'b1;
    cyc(4);
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    int r0;
    rx_ready = 1'b0;
    push_tx(8'hA5);
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL m0_txrdy got %b exp 0", tx_ready); end
    r0 = rx_rises;
    cs_begin(1'b0, 1'b0, 1'b0);
    n_checks++; if ({busy, miso_oe} !== 2'b11)
      begin n_fail++; $display("FAIL m0_busy_oe got %b exp 11", {busy, miso_oe}); end
    spi_word(8'h3C, 8, mi);
    cs_end();
    n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL m0_rx got %h exp 3c", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL m0_valid got %b exp 1", rx_valid); end
    n_checks++; if (mi !== 8'hA5)      begin n_fail++; $display("FAIL m0_miso got %h exp a5", mi); end
    n_checks++; if (rx_rises - r0 !== 1)
      begin n_fail++; $display("FAIL m0_pulses got %0d exp 1", rx_rises - r0); end
    accept_rx();
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL m0_accept got %b exp 0", rx_valid); end
  endtask

  task automatic test_modes();
    logic [7:0] mi;
    logic [1:0] m;
    for (int k = 0; k < 4; k++) begin
      m = 2'(k);
      push_tx(8'h81);
      cs_begin(m[1], m[0], 1'b1);
      spi_word(8'h7E, 8, mi);
      cs_end();
      n_checks++; if (rx_data !== 8'h7E)
        begin n_fail++; $display("FAIL mode%0d_rx got %h exp 7e", k, rx_data); end
      n_checks++; if (mi !== 8'h81)
        begin n_fail++; $display("FAIL mode%0d_miso got %h exp 81", k, mi); end
      accept_rx();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2;
    rx_ready = 1'b1;
    push_tx(8'h5A);
    clr_pulse();
    cs_begin(1'b0, 1'b0, 1'b0);
    spi_word(8'h01, 8, m1);
    spi_word(8'h02, 8, m2);
    cs_end();
    rx_ready = 1'b0;
    n_checks++; if (m1 !== 8'h5A)      begin n_fail++; $display("FAIL b2b_w1 got %h exp 5a", m1); end
    n_checks++; if (m2 !== 8'hFF)      begin n_fail++; $display("FAIL b2b_w2 got %h exp ff", m2); end
    n_checks++; if (rx_data !== 8'h02) begin n_fail++; $display("FAIL b2b_rx got %h exp 02", rx_data); end
    n_checks++; if (tx_underrun !== ErrExp)
      begin n_fail++; $display("FAIL b2b_underrun got %b exp %b", tx_underrun, ErrExp); end
    clr_pulse();
    n_checks++; if (tx_underrun !== 1'b0)
      begin n_fail++; $display("FAIL b2b_clr got %b exp 0", tx_underrun); end
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    rx_ready = 1'b0;
    clr_pulse();
    cs_begin(1'b0, 1'b0, 1'b0);
    spi_word(8'h11, 8, mi);
    spi_word(8'h22, 8, mi);
    cs_end();
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_rx got %h exp 11", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b exp 1", rx_valid); end
    n_checks++; if (rx_overrun !== ErrExp)
      begin n_fail++; $display("FAIL ovr_flag got %b exp %b", rx_overrun, ErrExp); end
    accept_rx();
    clr_pulse();
    n_checks++; if (rx_overrun !== 1'b0)
      begin n_fail++; $display("FAIL ovr_clr got %b exp 0", rx_overrun); end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int r0;
    r0 = rx_rises;
    cs_begin(1'b0, 1'b0, 1'b0);
    push_tx(8'hC3);
    spi_word(8'hAA, 5, mi);
    cs_n = 1'b1;
    cyc(3);
    n_checks++; if ({miso_oe, busy, miso} !== 3'b000)
      begin n_fail++; $display("FAIL abort_oe got %b exp 000", {miso_oe, busy, miso}); end
    cyc(6);
    n_checks++; if (rx_rises !== r0)
      begin n_fail++; $display("FAIL abort_valid got %0d pulses exp 0", rx_rises - r0); end
    cs_begin(1'b0, 1'b0, 1'b0);
    spi_word(8'h55, 8, mi);
    cs_end();
    n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL abort_next_rx got %h exp 55", rx_data); end
    n_checks++; if (mi !== 8'hC3)      begin n_fail++; $display("FAIL abort_held_tx got %h exp c3", mi); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    push_tx(8'h96);
    cs_begin(1'b0, 1'b0, 1'b0);
    push_tx(8'h69);
    spi_word(8'hF0, 4, mi);
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pre got %b exp 0", tx_ready); end
    rst_n = 1'b0;
    cyc(1);
    n_checks++; if ({miso, miso_oe, busy} !== 3'b000)
      begin n_fail++; $display("FAIL rmid_pins got %b exp 000", {miso, miso_oe, busy}); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_txrdy got %b exp 1", tx_ready); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_rxdata got %h exp 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", rx_valid); end
    n_checks++; if ({tx_underrun, rx_overrun} !== 2'b00)
      begin n_fail++; $display("FAIL rmid_flags got %b exp 00", {tx_underrun, rx_overrun}); end
    cs_n = 1'b1;
    sclk = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
  endtask

  initial begin
    rst_n    = 1'b0;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    cpol     = 1'b0;
    cpha     = 1'b0;
    lsb      = 1'b0;
    clr_err  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
